// File: rtl/mem_stage_hs.sv
// mem_stage_hs: MEM pipeline stage between EX and WB.
// Latches the EX result, issues loads/stores over an SRAM-like
// req/addr_ok/data_ok handshake, aligns and extends load data, and flags
// misaligned accesses.
// Ports:
//   clk, rst                      clock, async active-high reset
//   flush, stall_in               kill held instruction / hold stage register
//   in_*                          instruction fields from EX
//   dreq..dwdata                  data-memory request channel
//   daddr_ok, ddata_ok, drdata    data-memory response channel
//   stallreq                      stage busy with a memory access
//   wb_*                          results and exception info to WB
module mem_stage_hs #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned RA_W   = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                stall_in,
  input  logic                in_valid,
  input  logic [PC_W-1:0]     in_pc,
  input  logic                in_ld,
  input  logic                in_st,
  input  logic [1:0]          in_size,
  input  logic                in_unsigned,
  input  logic                in_rf_we,
  input  logic [RA_W-1:0]     in_rf_waddr,
  input  logic [DATA_W-1:0]   in_ex_result,
  input  logic [DATA_W-1:0]   in_st_data,
  output logic                dreq,
  output logic                dwr,
  output logic [1:0]          dsize,
  output logic [ADDR_W-1:0]   daddr,
  output logic [DATA_W/8-1:0] dwstrb,
  output logic [DATA_W-1:0]   dwdata,
  input  logic                daddr_ok,
  input  logic                ddata_ok,
  input  logic [DATA_W-1:0]   drdata,
  output logic                stallreq,
  output logic                wb_valid,
  output logic [PC_W-1:0]     wb_pc,
  output logic                wb_rf_we,
  output logic [RA_W-1:0]     wb_rf_waddr,
  output logic [DATA_W-1:0]   wb_rf_wdata,
  output logic                wb_excp_ale,
  output logic                wb_excp_ase,
  output logic [ADDR_W-1:0]   wb_badvaddr
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned LB = $clog2(NB);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_CANCEL = 3'd4;

  typedef struct packed {
    logic              valid;
    logic [PC_W-1:0]   pc;
    logic              ld;
    logic              st;
    logic [1:0]        size;
    logic              uns;
    logic              rf_we;
    logic [RA_W-1:0]   waddr;
    logic [DATA_W-1:0] ex;
    logic [DATA_W-1:0] sd;
  } stage_t;

  stage_t            stg_q;
  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] rdata_q;

  logic              capture;
  logic              in_mem_ok;
  logic              mem_q;
  logic              mis_q;
  logic              exc_q;
  logic [LB-1:0]     lane;
  logic [7:0]        fmask8;
  int unsigned       bm;
  logic [NB-1:0]     strb_c;
  logic [DATA_W-1:0] rep_c;
  logic [DATA_W-1:0] shifted_c;
  logic [DATA_W-1:0] fw_c;
  logic              sgn_c;
  logic [DATA_W-1:0] ld_res_c;

  // Access is misaligned if the low address bits are not a multiple of the
  // access size, or a dword is requested on a 32-bit datapath.
  function automatic logic misaligned(input logic [1:0] sz, input logic [LB-1:0] lo);
    logic [3:0] mask;
    mask = (4'd1 << sz) - 4'd1;
    return ((sz == 2'd3) && (DATA_W == 32)) || ((4'(lo) & mask) != 4'd0);
  endfunction

  assign stallreq  = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_CANCEL);
  assign capture   = !flush && !stall_in && !stallreq;
  assign in_mem_ok = in_valid && (in_ld || in_st) &&
                     !misaligned(in_size, in_ex_result[LB-1:0]);
  assign mem_q     = stg_q.ld || stg_q.st;
  assign mis_q     = misaligned(stg_q.size, stg_q.ex[LB-1:0]);
  assign exc_q     = mem_q && mis_q;
  assign lane      = stg_q.ex[LB-1:0];

  // Stage register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_q <= '0;
    end else if (flush) begin
      stg_q <= '0;
    end else if (capture) begin
      stg_q.valid <= in_valid;
      stg_q.pc    <= in_pc;
      stg_q.ld    <= in_ld;
      stg_q.st    <= in_st;
      stg_q.size  <= in_size;
      stg_q.uns   <= in_unsigned;
      stg_q.rf_we <= in_rf_we;
      stg_q.waddr <= in_rf_waddr;
      stg_q.ex    <= in_ex_result;
      stg_q.sd    <= in_st_data;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Read-data latch; data arriving for a flushed access is dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if ((state_q == S_WAIT) && ddata_ok && !flush) begin
      rdata_q <= drdata;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (flush)        state_d = S_IDLE;
        else if (capture) state_d = in_mem_ok ? S_REQ : S_IDLE;
      end
      S_REQ: begin
        // Once accepted, a data_ok is owed even if the instruction is killed
        if (daddr_ok)   state_d = flush ? S_CANCEL : S_WAIT;
        else if (flush) state_d = S_IDLE;
      end
      S_WAIT: begin
        if (ddata_ok)   state_d = flush ? S_IDLE : S_DONE;
        else if (flush) state_d = S_CANCEL;
      end
      S_CANCEL: begin
        if (ddata_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Store strobes/replication and load alignment/extension
  always_comb begin
    fmask8 = 8'h01;
    bm     = 0;
    fw_c   = '1;
    case (stg_q.size)
      2'd0:    begin fmask8 = 8'h01; bm = 0; end
      2'd1:    begin fmask8 = 8'h03; bm = 1; end
      2'd2:    begin fmask8 = 8'h0F; bm = 3; end
      default: begin fmask8 = 8'hFF; bm = 7; end
    endcase
    strb_c = NB'(fmask8) << lane;

    rep_c = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      rep_c[i*8 +: 8] = stg_q.sd[(i & bm)*8 +: 8];
    end

    shifted_c = rdata_q >> {lane, 3'b000};
    sgn_c     = shifted_c[DATA_W-1];
    case (stg_q.size)
      2'd0:    begin fw_c = DATA_W'(8'hFF);         sgn_c = shifted_c[7];  end
      2'd1:    begin fw_c = DATA_W'(16'hFFFF);      sgn_c = shifted_c[15]; end
      2'd2:    begin fw_c = DATA_W'(32'hFFFF_FFFF); sgn_c = shifted_c[31]; end
      default: begin fw_c = '1;                     sgn_c = shifted_c[DATA_W-1]; end
    endcase
    if (stg_q.uns) sgn_c = 1'b0;
    ld_res_c = (shifted_c & fw_c) | (sgn_c ? ~fw_c : '0);
  end

  // Memory request channel, driven only while a request is pending
  assign dreq   = (state_q == S_REQ);
  assign dwr    = dreq && stg_q.st;
  assign dsize  = dreq ? stg_q.size : 2'd0;
  assign daddr  = dreq ? stg_q.ex[ADDR_W-1:0] : '0;
  assign dwstrb = dwr ? strb_c : '0;
  assign dwdata = dwr ? rep_c : '0;

  // Writeback: non-memory and faulting instructions complete from IDLE
  assign wb_valid    = stg_q.valid &&
                       (((state_q == S_IDLE) && (!mem_q || mis_q)) || (state_q == S_DONE));
  assign wb_pc       = wb_valid ? stg_q.pc : '0;
  assign wb_rf_we    = wb_valid && stg_q.rf_we && !stg_q.st && !exc_q;
  assign wb_rf_waddr = wb_valid ? stg_q.waddr : '0;
  assign wb_rf_wdata = wb_valid ? (stg_q.ld ? ld_res_c : stg_q.ex) : '0;
  assign wb_excp_ale = wb_valid && stg_q.ld && mis_q;
  assign wb_excp_ase = wb_valid && stg_q.st && mis_q;
  assign wb_badvaddr = (wb_excp_ale || wb_excp_ase) ? stg_q.ex[ADDR_W-1:0] : '0;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Testbench for mem_stage_hs: directed table, randomized ops against an
// arithmetic reference model, and hand-written flush/reset/stall sequences.
// A second instance with DATA_W=64 covers dword accesses.
module tb_mem_stage_hs;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        flush, stall_in, in_valid, in_ld, in_st, in_unsigned, in_rf_we;
  logic [31:0] in_pc, in_ex_result, in_st_data;
  logic [1:0]  in_size;
  logic [4:0]  in_rf_waddr;
  logic        dreq, dwr, daddr_ok, ddata_ok, stallreq;
  logic [1:0]  dsize;
  logic [31:0] daddr, dwdata, drdata;
  logic [3:0]  dwstrb;
  logic        wb_valid, wb_rf_we, wb_excp_ale, wb_excp_ase;
  logic [31:0] wb_pc, wb_rf_wdata, wb_badvaddr;
  logic [4:0]  wb_rf_waddr;

  mem_stage_hs #(.DATA_W(32), .ADDR_W(32), .PC_W(32), .RA_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_in(stall_in),
    .in_valid(in_valid), .in_pc(in_pc), .in_ld(in_ld), .in_st(in_st),
    .in_size(in_size), .in_unsigned(in_unsigned), .in_rf_we(in_rf_we),
    .in_rf_waddr(in_rf_waddr), .in_ex_result(in_ex_result), .in_st_data(in_st_data),
    .dreq(dreq), .dwr(dwr), .dsize(dsize), .daddr(daddr), .dwstrb(dwstrb),
    .dwdata(dwdata), .daddr_ok(daddr_ok), .ddata_ok(ddata_ok), .drdata(drdata),
    .stallreq(stallreq), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rf_we(wb_rf_we),
    .wb_rf_waddr(wb_rf_waddr), .wb_rf_wdata(wb_rf_wdata),
    .wb_excp_ale(wb_excp_ale), .wb_excp_ase(wb_excp_ase), .wb_badvaddr(wb_badvaddr)
  );

  // 64-bit instance
  logic        flush64, stall64, v64, ld64, st64, uns64, rfwe64;
  logic [31:0] pc64;
  logic [63:0] ex64, sd64;
  logic [1:0]  sz64;
  logic [4:0]  wa64;
  logic        dreq64, dwr64, aok64, dok64, sreq64;
  logic [1:0]  dsize64;
  logic [31:0] daddr64;
  logic [63:0] dwdata64, drdata64;
  logic [7:0]  dwstrb64;
  logic        wbv64, wbwe64, ale64, ase64;
  logic [31:0] wbpc64, bad64;
  logic [63:0] wbd64;
  logic [4:0]  wbwa64;

  mem_stage_hs #(.DATA_W(64), .ADDR_W(32), .PC_W(32), .RA_W(5)) dut64 (
    .clk(clk), .rst(rst), .flush(flush64), .stall_in(stall64),
    .in_valid(v64), .in_pc(pc64), .in_ld(ld64), .in_st(st64),
    .in_size(sz64), .in_unsigned(uns64), .in_rf_we(rfwe64),
    .in_rf_waddr(wa64), .in_ex_result(ex64), .in_st_data(sd64),
    .dreq(dreq64), .dwr(dwr64), .dsize(dsize64), .daddr(daddr64), .dwstrb(dwstrb64),
    .dwdata(dwdata64), .daddr_ok(aok64), .ddata_ok(dok64), .drdata(drdata64),
    .stallreq(sreq64), .wb_valid(wbv64), .wb_pc(wbpc64), .wb_rf_we(wbwe64),
    .wb_rf_waddr(wbwa64), .wb_rf_wdata(wbd64),
    .wb_excp_ale(ale64), .wb_excp_ase(ase64), .wb_badvaddr(bad64)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Reference model: plain arithmetic on byte counts and lane offsets
  function automatic logic ref_mis(input logic [1:0] sz, input logic [31:0] addr);
    return (sz == 2'd3) || ((addr % (32'd1 << sz)) != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns,
                                           input logic [31:0] addr, input logic [31:0] rd);
    longint unsigned nbytes, mask, v;
    nbytes = longint'(1) << sz;
    mask   = (64'd1 << (8 * nbytes)) - 1;
    v      = (64'(rd) >> (8 * (addr % 4))) & mask;
    if (!uns && (((v >> (8 * nbytes - 1)) & 1) == 1)) v = v | ~mask;
    return 32'(v);
  endfunction

  function automatic logic [3:0] ref_strb(input logic [1:0] sz, input logic [31:0] addr);
    int nbytes;
    nbytes = 1 << sz;
    return 4'(((1 << nbytes) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] sd);
    if (sz == 2'd0) return (sd & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  // One instruction through the 32-bit stage, with configurable handshake latencies
  task automatic run_op(input string nm, input logic ld, input logic st, input logic [1:0] sz,
                        input logic uns, input logic rfwe, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [31:0] rd,
                        input int alat, input int dlat,
                        input logic [31:0] e_wdata, input logic [3:0] e_strb,
                        input logic [31:0] e_dwdata, input logic e_exc);
    logic [31:0] pc;
    logic [4:0]  wa;
    int          sr_cnt;
    logic        stable;
    pc = $urandom;
    wa = 5'($urandom);
    @(negedge clk);
    in_valid = 1'b1; in_pc = pc; in_ld = ld; in_st = st; in_size = sz;
    in_unsigned = uns; in_rf_we = rfwe; in_rf_waddr = wa;
    in_ex_result = addr; in_st_data = sd;
    @(negedge clk);
    in_valid = 1'b0; in_ld = 1'b0; in_st = 1'b0;
    if ((ld || st) && !e_exc) begin
      chk({nm, " dreq"}, dreq, 1);
      chk({nm, " dwr"}, dwr, st);
      chk({nm, " daddr"}, daddr, addr);
      chk({nm, " dsize"}, dsize, sz);
      chk({nm, " dwstrb"}, dwstrb, st ? e_strb : 4'h0);
      if (st) chk({nm, " dwdata"}, dwdata, e_dwdata);
      sr_cnt = 0;
      stable = 1'b1;
      for (int i = 0; i < alat; i++) begin
        sr_cnt += int'(stallreq);
        if (dreq !== 1'b1 || daddr !== addr) stable = 1'b0;
        @(negedge clk);
      end
      if (dreq !== 1'b1 || daddr !== addr) stable = 1'b0;
      chk({nm, " req_stable"}, stable, 1);
      sr_cnt += int'(stallreq);
      daddr_ok = 1'b1;
      @(negedge clk);
      daddr_ok = 1'b0;
      chk({nm, " dreq_wait"}, dreq, 0);
      chk({nm, " wb_valid_busy"}, wb_valid, 0);
      for (int i = 0; i < dlat; i++) begin
        sr_cnt += int'(stallreq);
        drdata = $urandom;
        @(negedge clk);
      end
      sr_cnt += int'(stallreq);
      ddata_ok = 1'b1; drdata = rd;
      @(negedge clk);
      ddata_ok = 1'b0; drdata = $urandom;
      chk({nm, " stall_cycles"}, 64'(sr_cnt), 64'(alat + dlat + 2));
    end else begin
      chk({nm, " no_dreq"}, dreq, 0);
    end
    chk({nm, " stallreq"}, stallreq, 0);
    chk({nm, " wb_valid"}, wb_valid, 1);
    chk({nm, " wb_pc"}, wb_pc, pc);
    chk({nm, " wb_rf_we"}, wb_rf_we, rfwe && !st && !e_exc);
    chk({nm, " wb_rf_waddr"}, wb_rf_waddr, wa);
    if (!e_exc) chk({nm, " wb_rf_wdata"}, wb_rf_wdata, e_wdata);
    chk({nm, " ale"}, wb_excp_ale, ld && e_exc);
    chk({nm, " ase"}, wb_excp_ase, st && e_exc);
    chk({nm, " badvaddr"}, wb_badvaddr, e_exc ? addr : 32'h0);
  endtask

  // Single access on the 64-bit instance, zero extra handshake latency
  task automatic op64(input string nm, input logic ld, input logic st, input logic [1:0] sz,
                      input logic uns, input logic [63:0] addr, input logic [63:0] sd,
                      input logic [63:0] rd, input logic [63:0] e_wdata,
                      input logic [7:0] e_strb, input logic [63:0] e_dwdata, input logic e_exc);
    @(negedge clk);
    v64 = 1'b1; ld64 = ld; st64 = st; sz64 = sz; uns64 = uns; ex64 = addr; sd64 = sd;
    @(negedge clk);
    v64 = 1'b0; ld64 = 1'b0; st64 = 1'b0;
    if (e_exc) begin
      chk({nm, " no_dreq"}, dreq64, 0);
      chk({nm, " wb_valid"}, wbv64, 1);
      chk({nm, " ale"}, ale64, ld);
      chk({nm, " badvaddr"}, bad64, addr[31:0]);
    end else begin
      chk({nm, " dreq"}, dreq64, 1);
      chk({nm, " dwstrb"}, dwstrb64, e_strb);
      if (st) chk({nm, " dwdata"}, dwdata64, e_dwdata);
      aok64 = 1'b1;
      @(negedge clk);
      aok64 = 1'b0; dok64 = 1'b1; drdata64 = rd;
      @(negedge clk);
      dok64 = 1'b0; drdata64 = '0;
      chk({nm, " wb_valid"}, wbv64, 1);
      chk({nm, " wb_rf_wdata"}, wbd64, e_wdata);
    end
  endtask

  typedef struct {
    string       nm;
    logic        ld, st;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr, sd, rd;
    int          alat, dlat;
    logic [31:0] e_wdata;
    logic [3:0]  e_strb;
    logic [31:0] e_dwdata;
    logic        e_exc;
  } vec_t;

  vec_t vt[13];

  initial begin
    logic        ld, st, uns, rfwe, mis;
    logic [1:0]  sz;
    logic [31:0] addr, sd, rd, ew;
    int          kind;

    rst = 1'b1;
    flush = 0; stall_in = 0; in_valid = 0; in_ld = 0; in_st = 0; in_unsigned = 0;
    in_rf_we = 0; in_pc = 0; in_ex_result = 0; in_st_data = 0; in_size = 0; in_rf_waddr = 0;
    daddr_ok = 0; ddata_ok = 0; drdata = 0;
    flush64 = 0; stall64 = 0; v64 = 0; ld64 = 0; st64 = 0; uns64 = 0; rfwe64 = 1;
    pc64 = 32'h40; ex64 = 0; sd64 = 0; sz64 = 0; wa64 = 5'd3; aok64 = 0; dok64 = 0; drdata64 = 0;

    #2;
    chk("rst dreq", dreq, 0);
    chk("rst stallreq", stallreq, 0);
    chk("rst wb_valid", wb_valid, 0);
    chk("rst wb_rf_wdata", wb_rf_wdata, 0);
    chk("rst dreq64", dreq64, 0);
    chk("rst wb_valid64", wbv64, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    //         nm        ld st sz  uns addr          sd            rd            al dl e_wdata        strb  e_dwdata       exc
    vt[0]  = '{"lb",     1, 0, 0, 0, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 1, 32'hFFFF_FF80, 4'h0, 32'h0,        0};
    vt[1]  = '{"lhu",    1, 0, 1, 1, 32'h0000_2002, 32'h0,        32'hBEEF_0001, 5, 0, 32'h0000_BEEF, 4'h0, 32'h0,        0};
    vt[2]  = '{"lh_mis", 1, 0, 1, 0, 32'h0000_2001, 32'h0,        32'h0,         0, 0, 32'h0,         4'h0, 32'h0,        1};
    vt[3]  = '{"sb",     0, 1, 0, 0, 32'h0000_0010, 32'h1234_56AB, 32'h0,        0, 0, 32'h0000_0010, 4'h1, 32'hABAB_ABAB, 0};
    vt[4]  = '{"sh",     0, 1, 1, 0, 32'h0000_0012, 32'h9876_1234, 32'h0,        1, 2, 32'h0000_0012, 4'hC, 32'h1234_1234, 0};
    vt[5]  = '{"lw",     1, 0, 2, 0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 2, 3, 32'hDEAD_BEEF, 4'h0, 32'h0,        0};
    vt[6]  = '{"sw_mis", 0, 1, 2, 0, 32'h0000_0102, 32'h5,        32'h0,         0, 0, 32'h0,         4'h0, 32'h0,        1};
    vt[7]  = '{"lbu",    1, 0, 0, 1, 32'h0000_1001, 32'h0,        32'h80FF_1234, 0, 0, 32'h0000_0012, 4'h0, 32'h0,        0};
    vt[8]  = '{"lh_hi",  1, 0, 1, 0, 32'h0000_1002, 32'h0,        32'h80FF_1234, 1, 1, 32'hFFFF_80FF, 4'h0, 32'h0,        0};
    vt[9]  = '{"ld_32",  1, 0, 3, 0, 32'h0000_0000, 32'h0,        32'h0,         0, 0, 32'h0,         4'h0, 32'h0,        1};
    vt[10] = '{"sw",     0, 1, 2, 0, 32'h0000_0200, 32'hCAFE_F00D, 32'h0,        0, 0, 32'h0000_0200, 4'hF, 32'hCAFE_F00D, 0};
    vt[11] = '{"alu",    0, 0, 1, 0, 32'h7777_1231, 32'h0,        32'h0,         0, 0, 32'h7777_1231, 4'h0, 32'h0,        0};
    vt[12] = '{"lb_pos", 1, 0, 0, 0, 32'h0000_3000, 32'h0,        32'h0000_007F, 0, 0, 32'h0000_007F, 4'h0, 32'h0,        0};

    foreach (vt[i])
      run_op(vt[i].nm, vt[i].ld, vt[i].st, vt[i].sz, vt[i].uns, 1'b1, vt[i].addr,
             vt[i].sd, vt[i].rd, vt[i].alat, vt[i].dlat, vt[i].e_wdata,
             vt[i].e_strb, vt[i].e_dwdata, vt[i].e_exc);

    // Flush while waiting for data: CANCEL until data_ok, nothing written back
    @(negedge clk);
    in_valid = 1; in_ld = 1; in_size = 2; in_ex_result = 32'h80; in_rf_we = 1;
    @(negedge clk);
    in_valid = 0; in_ld = 0; daddr_ok = 1;
    @(negedge clk);
    daddr_ok = 0; flush = 1;
    @(negedge clk);
    flush = 0;
    chk("cancel stallreq", stallreq, 1);
    chk("cancel wb_valid", wb_valid, 0);
    chk("cancel dreq", dreq, 0);
    @(negedge clk);
    chk("cancel stallreq2", stallreq, 1);
    ddata_ok = 1; drdata = 32'hFFFF_FFFF;
    @(negedge clk);
    ddata_ok = 0;
    chk("cancel done stallreq", stallreq, 0);
    chk("cancel done wb_valid", wb_valid, 0);
    run_op("lw_after_cancel", 1, 0, 2, 0, 1, 32'h84, 0, 32'h0BAD_F00D, 0, 0,
           32'h0BAD_F00D, 4'h0, 32'h0, 0);

    // Flush in REQ without addr_ok withdraws the request
    @(negedge clk);
    in_valid = 1; in_st = 1; in_size = 2; in_ex_result = 32'h90;
    @(negedge clk);
    in_valid = 0; in_st = 0;
    chk("wd dreq before", dreq, 1);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("wd dreq", dreq, 0);
    chk("wd stallreq", stallreq, 0);
    chk("wd wb_valid", wb_valid, 0);

    // Flush together with addr_ok still owes a data_ok
    @(negedge clk);
    in_valid = 1; in_ld = 1; in_size = 0; in_ex_result = 32'h91;
    @(negedge clk);
    in_valid = 0; in_ld = 0; flush = 1; daddr_ok = 1;
    @(negedge clk);
    flush = 0; daddr_ok = 0;
    chk("fa stallreq", stallreq, 1);
    ddata_ok = 1;
    @(negedge clk);
    ddata_ok = 0;
    chk("fa stallreq after", stallreq, 0);
    chk("fa wb_valid", wb_valid, 0);

    // stall_in holds a completed ALU instruction in place
    @(negedge clk);
    in_valid = 1; in_pc = 32'h1234; in_ex_result = 32'h11; in_rf_we = 1;
    @(negedge clk);
    stall_in = 1; in_pc = 32'h5555; in_ex_result = 32'h22;
    chk("stall wb_pc0", wb_pc, 32'h1234);
    @(negedge clk);
    chk("stall wb_valid", wb_valid, 1);
    chk("stall wb_pc1", wb_pc, 32'h1234);
    stall_in = 0;
    @(negedge clk);
    in_valid = 0;
    chk("stall release pc", wb_pc, 32'h5555);
    chk("stall release data", wb_rf_wdata, 32'h22);

    // Async reset in WAIT clears outputs at once; stale data_ok ignored
    @(negedge clk);
    in_valid = 1; in_ld = 1; in_size = 2; in_ex_result = 32'h40;
    @(negedge clk);
    in_valid = 0; in_ld = 0; daddr_ok = 1;
    @(negedge clk);
    daddr_ok = 0;
    chk("pre-rst stallreq", stallreq, 1);
    #2 rst = 1;
    #1;
    chk("midrst stallreq", stallreq, 0);
    chk("midrst dreq", dreq, 0);
    chk("midrst wb_valid", wb_valid, 0);
    @(negedge clk);
    rst = 0; ddata_ok = 1; drdata = 32'h1;
    @(negedge clk);
    ddata_ok = 0;
    chk("postrst stallreq", stallreq, 0);
    chk("postrst wb_valid", wb_valid, 0);

    // Randomized operations against the reference model
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 2);
      ld   = (kind == 0);
      st   = (kind == 1);
      sz   = 2'($urandom_range(0, 3));
      uns  = 1'($urandom);
      rfwe = 1'($urandom);
      addr = $urandom;
      if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
      sd   = $urandom;
      rd   = $urandom;
      mis  = (ld || st) && ref_mis(sz, addr);
      ew   = ld ? ref_load(sz, uns, addr, rd) : addr;
      run_op("rnd", ld, st, sz, uns, rfwe, addr, sd, rd,
             $urandom_range(0, 3), $urandom_range(0, 3),
             ew, ref_strb(sz, addr), ref_wdata(sz, sd), mis);
    end

    // 64-bit datapath: dword accesses and sign extension to 64 bits
    op64("sd64", 0, 1, 3, 0, 64'h8, 64'h1122_3344_5566_7788, 64'h0,
         64'h8, 8'hFF, 64'h1122_3344_5566_7788, 0);
    op64("ld64", 1, 0, 3, 0, 64'h8, 64'h0, 64'h8877_6655_4433_2211,
         64'h8877_6655_4433_2211, 8'h00, 64'h0, 0);
    op64("lw64", 1, 0, 2, 0, 64'hC, 64'h0, 64'h8000_0000_0000_0000,
         64'hFFFF_FFFF_8000_0000, 8'h00, 64'h0, 0);
    op64("sb64", 0, 1, 0, 0, 64'hD, 64'h5A, 64'h0,
         64'hD, 8'h20, 64'h5A5A_5A5A_5A5A_5A5A, 0);
    op64("ld64_mis", 1, 0, 3, 0, 64'hC, 64'h0, 64'h0, 64'h0, 8'h00, 64'h0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
